// File: rtl/mips_core_pkg.sv
// Shared core types: branch direction enum, address width, counter update helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    // Saturating up/down counter step for predictor tables. Counters are
    // carried in an 8-bit container so one function serves any table whose
    // counter width is 1..8; 'bits' is the real width.
    function automatic logic [7:0] sat_update(input logic [7:0]  ctr,
                                              input logic        taken,
                                              input int unsigned bits);
        logic [7:0] max_val;
        max_val = 8'((16'd1 << bits) - 16'd1);
        if (taken) begin
            return (ctr == max_val) ? ctr : ctr + 8'd1;
        end else begin
            return (ctr == 8'd0) ? ctr : ctr - 8'd1;
        end
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table of saturating counters with a post-reset init sweep.
// Latency: read combinational; write visible next cycle; sweep 2^IDX_BITS cycles.
// Backpressure: none; writes are dropped until ready=1.
// Ports: clk, rst_n (sync, active-low), rd_idx -> rd_msb (counter MSB),
//        wr_en/wr_idx/wr_taken (one counter step per cycle), ready (sweep done).
module bp_pht #(
    parameter int IDX_BITS = 9,
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_msb,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken,
    output logic                ready
);
    import mips_core_pkg::*;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int                  ENTRIES    = 2 ** IDX_BITS;
    localparam logic [CTR_BITS-1:0] WEAK_TAKEN = CTR_BITS'(1) << (CTR_BITS - 1);

    state_t              state;
    logic [IDX_BITS-1:0] init_ptr;
    logic [CTR_BITS-1:0] mem [ENTRIES];

    // Sweep FSM; ready is registered alongside the state so it rises exactly
    // when the last entry has been written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            init_ptr <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == '1) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: state <= INIT;
            endcase
        end
    end

    // Single write port: the sweep owns it during INIT, training during RUN.
    // Storage itself is not reset; the sweep rewrites every entry.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_ptr] <= WEAK_TAKEN;
        end else if (wr_en && rst_n) begin
            mem[wr_idx] <= CTR_BITS'(sat_update(8'(mem[wr_idx]), wr_taken, CTR_BITS));
        end
    end

    assign rd_msb = mem[rd_idx][CTR_BITS-1];

endmodule

// File: rtl/branch_predictor_gshare_param.sv
// Bimodal/gshare branch direction predictor with global history and mispredict counter.
// Latency: prediction combinational; training, GHR and count update next cycle.
// Backpressure: none; feedback is never stalled, it is ignored while o_ready=0.
// Ports: clk, rst_n (sync, active-low); request i_req_valid/i_req_pc/i_req_target ->
//        o_req_prediction, o_ready; feedback i_fb_valid/i_fb_pc/i_fb_prediction/
//        i_fb_outcome; status o_ghr (newest outcome in bit 0), o_mispredict_count.
module branch_predictor_gshare_param
    import mips_core_pkg::*;
#(
    parameter int IDX_BITS   = 9,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 8,
    parameter int PC_LSB     = 2,
    parameter int USE_GSHARE = 1,
    parameter int CNT_BITS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    input  logic [ADDR_WIDTH-1:0] i_req_target,
    output BranchOutcome          o_req_prediction,
    output logic                  o_ready,
    input  logic                  i_fb_valid,
    input  logic [ADDR_WIDTH-1:0] i_fb_pc,
    input  BranchOutcome          i_fb_prediction,
    input  BranchOutcome          i_fb_outcome,
    output logic [HIST_BITS-1:0]  o_ghr,
    output logic [CNT_BITS-1:0]   o_mispredict_count
);

    logic [HIST_BITS-1:0] ghr;
    logic [HIST_BITS-1:0] ghr_nxt;
    logic [IDX_BITS-1:0]  ghr_ext;
    logic [IDX_BITS-1:0]  req_idx;
    logic [IDX_BITS-1:0]  fb_idx;
    logic [CNT_BITS-1:0]  mis_cnt;
    logic                 pht_ready;
    logic                 rd_msb;
    logic                 fb_go;
    logic                 fb_taken;

    // Request strobe and target are advisory; upper PC bits do not index.
    logic unused_inputs;
    assign unused_inputs = ^{i_req_valid, i_req_target, i_req_pc, i_fb_pc};

    // History zero-extended to index width; in bimodal mode it is still
    // tracked but contributes nothing to the hash.
    always_comb begin
        ghr_ext = '0;
        if (USE_GSHARE != 0) begin
            ghr_ext[HIST_BITS-1:0] = ghr;
        end
    end

    // Both hashes use the committed (pre-update) history of this cycle.
    assign req_idx  = i_req_pc[PC_LSB +: IDX_BITS] ^ ghr_ext;
    assign fb_idx   = i_fb_pc[PC_LSB +: IDX_BITS] ^ ghr_ext;
    assign fb_go    = i_fb_valid && pht_ready;
    assign fb_taken = (i_fb_outcome == TAKEN);

    always_comb begin
        ghr_nxt    = ghr << 1;
        ghr_nxt[0] = fb_taken;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr     <= '0;
            mis_cnt <= '0;
        end else if (fb_go) begin
            ghr <= ghr_nxt;
            if ((i_fb_prediction != i_fb_outcome) && (mis_cnt != '1)) begin
                mis_cnt <= mis_cnt + 1'b1;
            end
        end
    end

    bp_pht #(
        .IDX_BITS (IDX_BITS),
        .CTR_BITS (CTR_BITS)
    ) u_pht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (req_idx),
        .rd_msb   (rd_msb),
        .wr_en    (fb_go),
        .wr_idx   (fb_idx),
        .wr_taken (fb_taken),
        .ready    (pht_ready)
    );

    // Until the sweep completes the table is meaningless; default to TAKEN.
    assign o_req_prediction   = (!pht_ready || rd_msb) ? TAKEN : NOT_TAKEN;
    assign o_ready            = pht_ready;
    assign o_ghr              = ghr;
    assign o_mispredict_count = mis_cnt;

endmodule

// File: tb/tb_branch_predictor_gshare_param.sv
// Directed bench: a bimodal instance (4-bit mispredict counter) and a gshare
// instance (default parameters) driven by the same request/feedback stream.
module tb_branch_predictor_gshare_param;
    import mips_core_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic [ADDR_WIDTH-1:0] req_target;
    logic                  fb_valid;
    logic [ADDR_WIDTH-1:0] fb_pc;
    BranchOutcome          fb_pred;
    BranchOutcome          fb_out;

    BranchOutcome b_pred, g_pred;
    logic         b_ready, g_ready;
    logic [7:0]   b_ghr, g_ghr;
    logic [3:0]   b_cnt;
    logic [31:0]  g_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predictor_gshare_param #(
        .USE_GSHARE (0),
        .CNT_BITS   (4)
    ) dut_b (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_req_valid        (req_valid),
        .i_req_pc           (req_pc),
        .i_req_target       (req_target),
        .o_req_prediction   (b_pred),
        .o_ready            (b_ready),
        .i_fb_valid         (fb_valid),
        .i_fb_pc            (fb_pc),
        .i_fb_prediction    (fb_pred),
        .i_fb_outcome       (fb_out),
        .o_ghr              (b_ghr),
        .o_mispredict_count (b_cnt)
    );

    branch_predictor_gshare_param dut_g (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_req_valid        (req_valid),
        .i_req_pc           (req_pc),
        .i_req_target       (req_target),
        .o_req_prediction   (g_pred),
        .o_ready            (g_ready),
        .i_fb_valid         (fb_valid),
        .i_fb_pc            (fb_pc),
        .i_fb_prediction    (fb_pred),
        .i_fb_outcome       (fb_out),
        .o_ghr              (g_ghr),
        .o_mispredict_count (g_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pred_b(input string tag, input logic [31:0] pc, input BranchOutcome exp);
        req_pc = pc;
        #1;
        chk(tag, 32'(b_pred), 32'(exp));
    endtask

    task automatic pred_g(input string tag, input logic [31:0] pc, input BranchOutcome exp);
        req_pc = pc;
        #1;
        chk(tag, 32'(g_pred), 32'(exp));
    endtask

    // One feedback beat, applied at the next rising edge.
    task automatic fb(input logic [31:0] pc, input BranchOutcome p, input BranchOutcome o);
        fb_pc    = pc;
        fb_pred  = p;
        fb_out   = o;
        fb_valid = 1'b1;
        @(posedge clk);
        #1;
        fb_valid = 1'b0;
    endtask

    // Reset for 3 cycles, then wait out the sweep. Optionally hammers
    // mispredicting feedback throughout the sweep, which must be ignored.
    task automatic do_reset(input bit fb_during_init);
        int n;
        fb_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pred_b("init_pred_b", 32'h1234, TAKEN);
        chk("init_ready_b", 32'(b_ready), 32'd0);
        chk("init_ready_g", 32'(g_ready), 32'd0);
        chk("init_ghr_g", 32'(g_ghr), 32'd0);
        chk("init_cnt_b", 32'(b_cnt), 32'd0);
        if (fb_during_init) begin
            fb_pc    = 32'h40;
            fb_pred  = TAKEN;
            fb_out   = NOT_TAKEN;
            fb_valid = 1'b1;
        end
        n = 0;
        while (!b_ready && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        fb_valid = 1'b0;
        chk("sweep_cycles", 32'(n), 32'd512);
        chk("ready_g", 32'(g_ready), 32'd1);
        chk("post_ghr_b", 32'(b_ghr), 32'd0);
        chk("post_ghr_g", 32'(g_ghr), 32'd0);
        chk("post_cnt_b", 32'(b_cnt), 32'd0);
        chk("post_cnt_g", g_cnt, 32'd0);
        pred_b("post_pred_b_40", 32'h40, TAKEN);
        pred_g("post_pred_g_40", 32'h40, TAKEN);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_pc     = '0;
        req_target = 32'hdead_beef;
        fb_valid   = 1'b0;
        fb_pc      = '0;
        fb_pred    = TAKEN;
        fb_out     = TAKEN;

        // Reset and sweep.
        do_reset(1'b0);
        pred_b("post_pred_b_any", 32'hABCD_0120, TAKEN);

        // Saturation on pc 0x40 (bimodal instance).
        fb(32'h40, NOT_TAKEN, NOT_TAKEN);
        pred_b("sat_nt1", 32'h40, NOT_TAKEN);
        fb(32'h40, NOT_TAKEN, NOT_TAKEN);
        fb(32'h40, NOT_TAKEN, NOT_TAKEN);
        pred_b("sat_nt3", 32'h40, NOT_TAKEN);
        fb(32'h40, TAKEN, TAKEN);
        pred_b("sat_t1", 32'h40, NOT_TAKEN);
        fb(32'h40, TAKEN, TAKEN);
        pred_b("sat_t2", 32'h40, TAKEN);

        // Index separation and aliasing.
        fb(32'h40, NOT_TAKEN, NOT_TAKEN);
        fb(32'h40, NOT_TAKEN, NOT_TAKEN);
        pred_b("sep_44", 32'h44, TAKEN);
        pred_b("alias_840", 32'h840, NOT_TAKEN);

        // Same-cycle request and feedback on entry 0x20 (counter 2'b10).
        req_pc   = 32'h80;
        fb_pc    = 32'h80;
        fb_pred  = TAKEN;
        fb_out   = NOT_TAKEN;
        fb_valid = 1'b1;
        #1;
        chk("collide_pre", 32'(b_pred), 32'(TAKEN));
        @(posedge clk);
        #1;
        fb_valid = 1'b0;
        #1;
        chk("collide_post", 32'(b_pred), 32'(NOT_TAKEN));
        chk("ghr_b_hist", 32'(b_ghr), 32'h18);
        chk("cnt_b_one", 32'(b_cnt), 32'd1);
        chk("cnt_g_one", g_cnt, 32'd1);

        // Mid-RUN reset with feedback during the sweep.
        do_reset(1'b1);
        pred_b("rst_840", 32'h840, TAKEN);
        pred_b("rst_80", 32'h80, TAKEN);

        // Gshare history and hashing.
        fb(32'h100, TAKEN, TAKEN);
        fb(32'h104, NOT_TAKEN, NOT_TAKEN);
        fb(32'h108, TAKEN, TAKEN);
        chk("ghr_g_101", 32'(g_ghr), 32'h05);
        pred_g("gs_idx5_e0", 32'h14, TAKEN);
        fb(32'h14, NOT_TAKEN, NOT_TAKEN);
        fb(32'h28, NOT_TAKEN, NOT_TAKEN);
        chk("ghr_g_14", 32'(g_ghr), 32'h14);
        pred_g("gs_e0_nt", 32'h50, NOT_TAKEN);
        pred_g("gs_idx5_e11", 32'h14, TAKEN);
        pred_b("bm_idx5", 32'h14, NOT_TAKEN);

        // Mispredict counter saturation.
        for (int i = 0; i < 14; i++) fb(32'h200, TAKEN, NOT_TAKEN);
        chk("cnt_b_14", 32'(b_cnt), 32'd14);
        for (int i = 0; i < 6; i++) fb(32'h200, TAKEN, NOT_TAKEN);
        chk("cnt_b_sat", 32'(b_cnt), 32'd15);
        chk("cnt_g_20", g_cnt, 32'd20);
        chk("ghr_b_zero", 32'(b_ghr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
